// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between uart_tx_arbiter, its requesters and the channel_uart_transmitter.
// slave = arbiter view, master = requester/transmitter environment view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [8*NUM_REQ-1:0]  req_key;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic                  err;
  logic [15:0]           tx_data;
  logic [7:0]            tx_key;
  logic                  tx_transfer;
  logic                  tx_busy;
  logic [2:0]            owner;

  modport slave (
    input  req, req_data, req_key, tx_busy,
    output gnt, done, err, tx_data, tx_key, tx_transfer, owner
  );

  modport master (
    output req, req_data, req_key, tx_busy,
    input  gnt, done, err, tx_data, tx_key, tx_transfer, owner
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one channel_uart_transmitter among NUM_REQ requesters.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest req index wins, no pointer).
//
// state     | meaning
// IDLE      | waiting for a request with the transmitter idle
// STROBE    | driving transfer_data for STROBE_CYCLES cycles
// WAIT_RISE | waiting for tx_busy to rise, bounded by the timeout
// WAIT_FALL | frame in flight, waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STROBE_CYCLES  = 5
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_RISE, WAIT_FALL} state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic [NUM_REQ-1:0] done_q, done_nxt;
  logic               err_q, err_nxt;
  logic               xfer_q, xfer_nxt;
  logic [15:0]        data_q, data_nxt;
  logic [7:0]         key_q, key_nxt;
  logic [2:0]         owner_q, owner_nxt;

  logic               any_req;
  logic [2:0]         lo_win;
  logic [2:0]         winner;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] owner_oh;
  logic [15:0]        win_data;
  logic [7:0]         win_key;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [2:0]         ptr_q, ptr_nxt;
  logic [2:0]         owner_inc;
  logic               hi_found;
  logic [2:0]         hi_win;
`endif

  // lo_win is the lowest set index overall; hi_win the lowest at or above the pointer.
  always_comb begin
    any_req = 1'b0;
    lo_win  = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
    hi_found = 1'b0;
    hi_win   = '0;
`endif
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        any_req = 1'b1;
        lo_win  = 3'(i);
`ifndef UART_ARB_FIXED_PRIO_EN
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_win   = 3'(i);
        end
`endif
      end
    end
`ifdef UART_ARB_FIXED_PRIO_EN
    winner = lo_win;
`else
    winner = hi_found ? hi_win : lo_win;
`endif
  end

  always_comb begin
    win_oh   = '0;
    owner_oh = '0;
    win_data = '0;
    win_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i]   = (int'(winner) == i);
      owner_oh[i] = (int'(owner_q) == i);
      if (int'(winner) == i) begin
        win_data = bus.req_data[16*i +: 16];
        win_key  = bus.req_key[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    gnt_nxt   = '0;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    xfer_nxt  = 1'b0;
    data_nxt  = data_q;
    key_nxt   = key_q;
    owner_nxt = owner_q;
    unique case (state)
      IDLE: begin
        // A done pulse blocks arbitration so at least one quiet cycle separates frames.
        if (any_req && !bus.tx_busy && (done_q == '0)) begin
          gnt_nxt   = win_oh;
          data_nxt  = win_data;
          key_nxt   = win_key;
          owner_nxt = winner;
          timer_nxt = TW'(STROBE_CYCLES - 1);
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        xfer_nxt = 1'b1;
        if (timer == '0) begin
          // Remaining budget so the timeout lands TIMEOUT_CYCLES after the strobe starts.
          timer_nxt = TW'(TIMEOUT_CYCLES - STROBE_CYCLES);
          state_nxt = WAIT_RISE;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      WAIT_RISE: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_FALL;
        end else if (timer == '0) begin
          done_nxt  = owner_oh;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      WAIT_FALL: begin
        if (!bus.tx_busy) begin
          done_nxt  = owner_oh;
          state_nxt = IDLE;
        end
      end
    endcase
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    owner_inc = (int'(owner_q) == NUM_REQ - 1) ? 3'd0 : owner_q + 3'd1;
    ptr_nxt   = (done_nxt != '0) ? owner_inc : ptr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_nxt;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      xfer_q  <= 1'b0;
      data_q  <= '0;
      key_q   <= '0;
      owner_q <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      gnt_q   <= gnt_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      xfer_q  <= xfer_nxt;
      data_q  <= data_nxt;
      key_q   <= key_nxt;
      owner_q <= owner_nxt;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.tx_transfer = xfer_q;
  assign bus.tx_data     = data_q;
  assign bus.tx_key      = key_q;
  assign bus.owner       = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a round-robin / fixed-priority reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N      = 4;
  localparam int STROBE = 5;
  localparam int TMO    = 1024;
`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(TMO), .STROBE_CYCLES(STROBE)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] words [N];
  logic [7:0]  keys  [N];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_fp;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference: first requester at/after the pointer (mod N), or the lowest index when fixed.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = FIXED ? k : (p + k) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic load_words();
    for (int i = 0; i < N; i++) begin
      bus.req_data[16*i +: 16] = words[i];
      bus.req_key[8*i +: 8]    = keys[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bus.req = '0; bus.tx_busy = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_xfer", 32'(bus.tx_transfer), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'd0);
    chk("rst_key", 32'(bus.tx_key), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    reset = 1'b1;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int lat);
    g = '0; lat = 0;
    while (g == '0 && lat < 50) begin
      @(negedge clk);
      lat++;
      g = bus.gnt;
    end
    chk("gnt_seen", 32'(g != '0), 32'd1);
  endtask

  // From the gnt cycle: strobe width, data hold, transmitter busy window, done pulse, idle gap.
  task automatic complete_frame(input logic [N-1:0] exp_done, input logic [15:0] exp_data,
                                input logic [7:0] exp_key, input int rise_dly, input int busy_len);
    int width;
    logic moved;
    width = 0; moved = 1'b0;
    @(negedge clk);
    chk("gnt_pulse", 32'(bus.gnt), 32'd0);
    chk("xfer_rise", 32'(bus.tx_transfer), 32'd1);
    while (bus.tx_transfer === 1'b1 && width < 40) begin
      width++;
      if (bus.tx_data !== exp_data || bus.tx_key !== exp_key) moved = 1'b1;
      @(negedge clk);
    end
    chk("xfer_width", 32'(width), 32'(STROBE));
    chk("strobe_hold", 32'(moved), 32'd0);
    repeat (rise_dly) @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (busy_len) @(negedge clk);
    chk("done_early", 32'(bus.done), 32'd0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("err", 32'(bus.err), 32'd0);
    chk("data_after", 32'(bus.tx_data), 32'(exp_data));
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("idle_gap", 32'(bus.gnt), 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [N-1:0] r, input logic [N-1:0] e,
                         input int rise_dly, input int busy_len);
    logic [N-1:0] g;
    int lat, w;
    bus.req = r;
    wait_gnt(g, lat);
    bus.req = '0;
    w = oh_idx(e);
    chk({tag, "_gnt"}, 32'(g), 32'(e));
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_owner"}, 32'(bus.owner), 32'(w));
    chk({tag, "_data"}, 32'(bus.tx_data), 32'(words[w]));
    chk({tag, "_key"}, 32'(bus.tx_key), 32'(keys[w]));
    complete_frame(e, words[w], keys[w], rise_dly, busy_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g, pend, newb;
    int lat, cnt, mp, w;
    logic seen;

    vecs[0] = '{4'b1111, 4'b0001, 4'b0001};
    vecs[1] = '{4'b1111, 4'b0010, 4'b0001};
    vecs[2] = '{4'b1111, 4'b0100, 4'b0001};
    vecs[3] = '{4'b1111, 4'b1000, 4'b0001};
    vecs[4] = '{4'b1111, 4'b0001, 4'b0001};
    vecs[5] = '{4'b0001, 4'b0001, 4'b0001};
    vecs[6] = '{4'b1001, 4'b1000, 4'b0001};
    vecs[7] = '{4'b0110, 4'b0010, 4'b0010};
    vecs[8] = '{4'b0011, 4'b0001, 4'b0001};
    vecs[9] = '{4'b1100, 4'b0100, 4'b0100};

    bus.req = '0; bus.tx_busy = 1'b0; bus.req_data = '0; bus.req_key = '0;

    // Single request with a long transmitter frame.
    for (int i = 0; i < N; i++) begin words[i] = 16'h0; keys[i] = 8'h0; end
    words[0] = 16'h0101; keys[0] = 8'h01;
    load_words();
    do_reset();
    run_vec("single", 4'b0001, 4'b0001, 3, 200);

    // Directed table from a fresh pointer.
    for (int i = 0; i < N; i++) begin words[i] = 16'hA000 + 16'(i); keys[i] = 8'h50 + 8'(i); end
    load_words();
    do_reset();
    for (int v = 0; v < 10; v++)
      run_vec($sformatf("vec%0d", v), vecs[v].req, FIXED ? vecs[v].exp_fp : vecs[v].exp_rr, v % 3, 1 + v % 4);

    // Timeout: tx_busy never rises.
    do_reset();
    bus.req = 4'b0010;
    wait_gnt(g, lat);
    bus.req = '0;
    chk("tmo_gnt", 32'(g), 32'b0010);
    @(negedge clk);
    chk("tmo_xfer", 32'(bus.tx_transfer), 32'd1);
    cnt = 0;
    while (bus.done == '0 && cnt < TMO + 50) begin @(negedge clk); cnt++; end
    chk("tmo_done", 32'(bus.done), 32'b0010);
    chk("tmo_err", 32'(bus.err), 32'd1);
    chk("tmo_cycles", 32'(cnt), 32'(TMO));
    @(negedge clk);
    chk("tmo_err_pulse", 32'(bus.err), 32'd0);
    run_vec("tmo_next", 4'b0111, FIXED ? 4'b0001 : 4'b0100, 1, 2);
    run_vec("tmo_wrap", 4'b0011, 4'b0001, 0, 1);

    // Reset in WAIT_FALL: outputs clear at once, done is lost, pointer returns to 0.
    do_reset();
    run_vec("mf_pre", 4'b0010, 4'b0010, 1, 1);
    bus.req = 4'b0100;
    wait_gnt(g, lat);
    bus.req = '0;
    chk("mf_gnt", 32'(g), 32'b0100);
    cnt = 0;
    @(negedge clk);
    while (bus.tx_transfer === 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    bus.tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mf_xfer", 32'(bus.tx_transfer), 32'd0);
    chk("mf_gnt0", 32'(bus.gnt), 32'd0);
    chk("mf_owner", 32'(bus.owner), 32'd0);
    chk("mf_data", 32'(bus.tx_data), 32'd0);
    @(negedge clk);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.done != '0) seen = 1'b1; end
    chk("mf_no_done", 32'(seen), 32'd0);
    run_vec("mf_after", 4'b0101, 4'b0001, 2, 2);

    // Transmitter already busy in IDLE.
    bus.tx_busy = 1'b1;
    bus.req = 4'b0001;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.gnt != '0) seen = 1'b1; end
    chk("xb_no_gnt", 32'(seen), 32'd0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    chk("xb_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    complete_frame(4'b0001, words[0], keys[0], 1, 2);

    // Random held requests against the reference model.
    do_reset();
    mp = 0; pend = '0;
    for (int it = 0; it < 40; it++) begin
      newb = 4'($urandom_range(0, 15)) & ~pend;
      for (int i = 0; i < N; i++)
        if (newb[i]) begin words[i] = 16'($urandom); keys[i] = 8'($urandom); end
      pend |= newb;
      if (pend == '0) pend = 4'b1000;
      load_words();
      bus.req = pend;
      w = model_pick(pend, mp);
      wait_gnt(g, lat);
      chk("rnd_gnt", 32'(g), 32'(1 << w));
      chk("rnd_lat", 32'(lat), 32'd1);
      chk("rnd_data", 32'(bus.tx_data), 32'(words[w]));
      chk("rnd_key", 32'(bus.tx_key), 32'(keys[w]));
      pend[w] = 1'b0;
      bus.req = pend;
      complete_frame(4'(1 << w), words[w], keys[w], $urandom_range(0, 4), $urandom_range(1, 6));
      mp = (w + 1) % N;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
